// File: rtl/i2s_pkg.sv
// Shared I2S definitions: word-select levels, legal parameter ranges and the
// slot-to-WS mapping used by both transmit and receive sides.
package i2s_pkg;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  localparam int unsigned SAMPLE_W_MIN = 8;
  localparam int unsigned SAMPLE_W_MAX = 32;
  localparam int unsigned CLK_DIV_MIN  = 2;

  // WS for bit slot n: right channel is flagged one slot ahead of its MSB.
  function automatic logic ws_for_slot(input int unsigned n, input int unsigned sample_w);
    if ((n >= sample_w - 1) && (n <= 2 * sample_w - 2)) begin
      return WS_RIGHT;
    end
    return WS_LEFT;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides the fabric clock into BCLK and flags the
// fabric cycle on which BCLK rises or falls.
module i2s_bclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  output logic o_bclk,
  output logic o_fall_c,
  output logic o_rise_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_bclk;
  logic             w_term;

  assign w_term = (r_div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (!i_enable) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_term) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Strobes mark the cycle whose clock edge performs the toggle.
  assign o_fall_c = i_enable && w_term && r_bclk;
  assign o_rise_c = i_enable && w_term && !r_bclk;
  assign o_bclk   = r_bclk;

endmodule

// File: rtl/i2s_tx_master.sv
// I2S master transmitter: one-entry sample buffer, frame loader, MSB-first
// shifter and saturating underrun counter driven by the BCLK fall strobe.
module i2s_tx_master
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned UCNT_W   = 16
) (
  input  logic                CLK_IP_i,
  input  logic                RST_IP_n_i,
  input  logic                enable_i,
  input  logic [SAMPLE_W-1:0] sample_left_i,
  input  logic [SAMPLE_W-1:0] sample_right_i,
  input  logic                sample_valid_i,
  output logic                sample_ready_o,
  output logic                bclk_o,
  output logic                ws_o,
  output logic                sdata_o,
  output logic                frame_start_o,
  output logic                underrun_o,
  output logic [UCNT_W-1:0]   underrun_cnt_o
);

  localparam int unsigned FRAME_W = 2 * SAMPLE_W;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  logic w_fall;
  logic w_rise_unused;
  logic w_bclk;

  i2s_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .i_clk    (CLK_IP_i),
    .i_rst_n  (RST_IP_n_i),
    .i_enable (enable_i),
    .o_bclk   (w_bclk),
    .o_fall_c (w_fall),
    .o_rise_c (w_rise_unused)
  );

  // r_bit_cnt holds the slot that the next fall event will present.
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [FRAME_W-1:0] r_shift;
  logic [FRAME_W-1:0] r_buf;
  logic               r_ready;
  logic               r_ws;
  logic               r_sdata;
  logic               r_frame_start;
  logic               r_underrun;
  logic [UCNT_W-1:0]  r_ucnt;

  logic               w_load;
  logic               w_capture;
  logic               w_ws_next;
  logic [FRAME_W-1:0] w_shift_src;

  always_comb begin
    w_load      = w_fall && (r_bit_cnt == '0);
    w_capture   = sample_valid_i && r_ready;
    w_ws_next   = ws_for_slot(32'(r_bit_cnt), SAMPLE_W);
    w_shift_src = r_shift;
    if (w_load) begin
      w_shift_src = r_ready ? '0 : r_buf;
    end
  end

  // Serial path: cleared while disabled so a restart begins at slot 0.
  always_ff @(posedge CLK_IP_i or negedge RST_IP_n_i) begin
    if (!RST_IP_n_i) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_ws          <= WS_LEFT;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else if (!enable_i) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_ws          <= WS_LEFT;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load && r_ready;
      if (w_fall) begin
        r_bit_cnt <= (r_bit_cnt == BIT_W'(FRAME_W - 1)) ? '0 : r_bit_cnt + BIT_W'(1);
        r_ws      <= w_ws_next;
        r_sdata   <= w_shift_src[FRAME_W-1];
        r_shift   <= {w_shift_src[FRAME_W-2:0], 1'b0};
      end
    end
  end

  // Holding buffer stays live across disable; a load frees it, a capture fills it.
  always_ff @(posedge CLK_IP_i or negedge RST_IP_n_i) begin
    if (!RST_IP_n_i) begin
      r_buf   <= '0;
      r_ready <= 1'b1;
    end else if (w_capture) begin
      r_buf   <= {sample_left_i, sample_right_i};
      r_ready <= 1'b0;
    end else if (w_load && !r_ready) begin
      r_ready <= 1'b1;
    end
  end

  always_ff @(posedge CLK_IP_i or negedge RST_IP_n_i) begin
    if (!RST_IP_n_i) begin
      r_ucnt <= '0;
    end else if (w_load && r_ready && (r_ucnt != '1)) begin
      r_ucnt <= r_ucnt + UCNT_W'(1);
    end
  end

  assign sample_ready_o = r_ready;
  assign bclk_o         = w_bclk;
  assign ws_o           = r_ws;
  assign sdata_o        = r_sdata;
  assign frame_start_o  = r_frame_start;
  assign underrun_o     = r_underrun;
  assign underrun_cnt_o = r_ucnt;

endmodule
